// File: rtl/instr_mem_loader_pkg.sv
// Shared fetch/memory constants plus the instruction-memory loader state encoding.
package instr_mem_loader_pkg;

    localparam int          WORD_W = 32;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CSUM  = 3'd5,
        DONE  = 3'd6
    } loader_state_t;

    function automatic logic accepts_byte(input loader_state_t s);
        return (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Packs little-endian bytes into a 32-bit word; word only changes when lane 3 completes it.
module loader_byte_packer
    import instr_mem_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_byte,
    input  logic [1:0]        lane,
    input  logic              accept,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    logic [23:0]       low_r;
    logic [WORD_W-1:0] word_r;
    logic              full_r;

    // Lanes 0-2 collect in a shadow so the published word holds steady between writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            low_r  <= 24'd0;
            word_r <= {WORD_W{1'b0}};
            full_r <= 1'b0;
        end else begin
            full_r <= accept && (lane == 2'd3);
            if (accept) begin
                case (lane)
                    2'd0:    low_r[7:0]   <= in_byte;
                    2'd1:    low_r[15:8]  <= in_byte;
                    2'd2:    low_r[23:16] <= in_byte;
                    2'd3:    word_r       <= {in_byte, low_r};
                    default: word_r       <= word_r;
                endcase
            end
        end
    end

    assign word      = word_r;
    assign word_full = full_r;

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: length-prefixed byte stream -> 32-bit word writes while holding the core.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;

    loader_state_t    state_r;
    loader_state_t    state_n;
    logic [15:0]      count_r;
    logic [IDX_W-1:0] idx_r;
    logic [1:0]       lane_r;
    logic             err_r;
    logic [31:0]      addr_r;
    logic             in_ready_r;
    logic             cpu_hold_r;
    logic             done_r;
    logic             accept_s;
    logic             last_s;
    logic [15:0]      len_s;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       csum_r;
`endif

    assign accept_s = in_valid && in_ready_r;
    assign len_s    = {in_data, count_r[7:0]};
    assign last_s   = ((16'(idx_r) + 16'd1) == count_r);

    // Next-state decode.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:  if (start) state_n = LEN0; else state_n = IDLE;
            LEN0:  if (accept_s) state_n = LEN1; else state_n = LEN0;
            LEN1: begin
                if (!accept_s)                     state_n = LEN1;
                else if (len_s == 16'd0)           state_n = DONE;
                else if (len_s > 16'(DEPTH_WORDS)) state_n = DONE;
                else                               state_n = DATA;
            end
            DATA:  if (accept_s && (lane_r == 2'd3)) state_n = WRITE; else state_n = DATA;
            WRITE: begin
                if (!last_s) state_n = DATA;
`ifdef LOADER_CHECKSUM_EN
                else         state_n = CSUM;
`else
                else         state_n = DONE;
`endif
            end
            CSUM:  if (accept_s) state_n = DONE; else state_n = CSUM;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_n;
    end

    // Length, word index, lane, write address and sticky error.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= 16'd0;
            idx_r   <= {IDX_W{1'b0}};
            lane_r  <= 2'd0;
            err_r   <= 1'b0;
            addr_r  <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
            csum_r  <= 8'd0;
`endif
        end else begin
            case (state_r)
                IDLE: if (start) begin
                    count_r <= 16'd0;
                    idx_r   <= {IDX_W{1'b0}};
                    lane_r  <= 2'd0;
                    err_r   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    csum_r  <= 8'd0;
`endif
                end
                LEN0: if (accept_s) count_r[7:0] <= in_data;
                LEN1: if (accept_s) begin
                    count_r[15:8] <= in_data;
                    if (len_s > 16'(DEPTH_WORDS)) err_r <= 1'b1;
                end
                DATA: if (accept_s) begin
                    lane_r <= lane_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_r <= csum_r ^ in_data;
`endif
                    // Address is captured with the last byte so it lines up with the write cycle.
                    if (lane_r == 2'd3) addr_r <= BASE_ADDR + 32'(idx_r) * PC_INC;
                end
                WRITE: idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
`ifdef LOADER_CHECKSUM_EN
                CSUM: if (accept_s && (in_data != csum_r)) err_r <= 1'b1;
`endif
                default: begin
                end
            endcase
        end
    end

    // Status outputs registered from the upcoming state.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_ready_r <= 1'b0;
            cpu_hold_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            in_ready_r <= accepts_byte(state_n);
            cpu_hold_r <= (state_n != IDLE) && (state_n != DONE);
            done_r     <= (state_n == DONE);
        end
    end

    loader_byte_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .in_byte   (in_data),
        .lane      (lane_r),
        .accept    (accept_s && (state_r == DATA)),
        .word      (mem_wd),
        .word_full (mem_we)
    );

    assign in_ready = in_ready_r;
    assign mem_addr = addr_r;
    assign cpu_hold = cpu_hold_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: vector table, hand sequences and randomized loads vs a reference model.
module tb_instr_mem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          DEPTH = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready, mem_we, cpu_hold, done, err;
    logic [31:0] mem_addr, mem_wd;

    instr_mem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] len;
        logic [31:0] w0;
        logic [31:0] w1;
        int          gap;
        bit          mid_start;
        bit          csum_bad;
        bit          exp_err;
        int          exp_n;
    } vec_t;

    vec_t        vecs[$];
    logic [7:0]  data_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          n_run = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        done_err = 1'b0;
    int          hold_bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Write/done monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wd);
            if (cpu_hold !== 1'b1) hold_bad = hold_bad + 1;
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            done_err = err;
            if (cpu_hold !== 1'b0) hold_bad = hold_bad + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic add_vec(input logic [15:0] len, input logic [31:0] w0, input logic [31:0] w1,
                           input int gap, input bit ms, input bit cb, input bit ee, input int en);
        vec_t v;
        v = '{len, w0, w1, gap, ms, cb, ee, en};
        vecs.push_back(v);
    endtask

    task automatic fill_data(input int n, input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] w;
        data_q.delete();
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? w0 : (i == 1) ? w1 : (w0 ^ (32'h0101_0101 * 32'(i)));
            for (int k = 0; k < 4; k++) data_q.push_back(w[8*k +: 8]);
        end
    endtask

    // Holds a byte until accepted; called and returns at a negedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'(n), 32'd0);
        @(negedge clock);
        in_valid = 1'b0;
        if (gap == 1) @(negedge clock);
        else if (gap == 2) repeat ($urandom_range(0, 2)) @(negedge clock);
    endtask

    task automatic run_load(input logic [15:0] len, input int gap, input bit mid_start,
                            input bit csum_bad, input bit exp_err, input int exp_n, input string nm);
        int          t0, d0, k, exp_t, nw;
        logic [7:0]  x;
        logic [31:0] w;
        wr_addr_q.delete();
        wr_data_q.delete();
        hold_bad = 0;
        d0 = done_cnt;
        t0 = cyc;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk({nm, "_hold_on"}, 32'(cpu_hold), 32'd1);
        send_byte(len[7:0], gap);
        send_byte(len[15:8], gap);
        x = 8'd0;
        for (int i = 0; i < 4 * exp_n; i++) begin
            if (mid_start && i == 2) start = 1'b1;
            send_byte(data_q[i], gap);
            start = 1'b0;
            x = x ^ data_q[i];
        end
        exp_t = 3 + 5 * exp_n;
`ifdef LOADER_CHECKSUM_EN
        if (exp_n > 0) begin
            send_byte(csum_bad ? ~x : x, gap);
            exp_t = exp_t + 1;
        end
`endif
        k = 0;
        while (done_cnt == d0 && k < 60) begin
            @(negedge clock);
            k++;
        end
        chk({nm, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
        if (done_cnt == d0) begin
            do_reset();
            return;
        end
        chk({nm, "_err"}, 32'(done_err), 32'(exp_err));
        chk({nm, "_nwrites"}, 32'(wr_addr_q.size()), 32'(exp_n));
        nw = (wr_addr_q.size() < exp_n) ? wr_addr_q.size() : exp_n;
        for (int i = 0; i < nw; i++) begin
            w = {data_q[4*i+3], data_q[4*i+2], data_q[4*i+1], data_q[4*i]};
            chk({nm, "_addr"}, wr_addr_q[i], BASE + 32'(4 * i));
            chk({nm, "_wd"}, wr_data_q[i], w);
        end
        if (gap == 0) chk({nm, "_time"}, 32'(done_cyc - t0), 32'(exp_t));
        else if (gap == 1) chk({nm, "_slow"}, 32'(done_cyc - t0 >= exp_t + 3 * exp_n), 32'd1);
        repeat (2) @(negedge clock);
        chk({nm, "_ready_idle"}, 32'(in_ready), 32'd0);
        chk({nm, "_one_done"}, 32'(done_cnt - d0), 32'd1);
        chk({nm, "_hold_bad"}, 32'(hold_bad), 32'd0);
        if (exp_n > 0) begin
            w = {data_q[4*exp_n-1], data_q[4*exp_n-2], data_q[4*exp_n-3], data_q[4*exp_n-4]};
            chk({nm, "_addr_hold"}, mem_addr, BASE + 32'(4 * (exp_n - 1)));
            chk({nm, "_wd_hold"}, mem_wd, w);
        end
    endtask

    initial begin
        logic [15:0] len;
        int          n;
        bit          e;
        bit          cb;

        add_vec(16'd2,   32'h0000_0013, 32'h0010_0093, 0, 1'b0, 1'b0, 1'b0, 2);
        add_vec(16'd0,   32'h0,         32'h0,         0, 1'b0, 1'b0, 1'b0, 0);
        add_vec(16'd65,  32'h0,         32'h0,         0, 1'b0, 1'b0, 1'b1, 0);
        add_vec(16'h100, 32'h0,         32'h0,         0, 1'b0, 1'b0, 1'b1, 0);
        add_vec(16'd2,   32'h0000_0013, 32'h0010_0093, 1, 1'b1, 1'b0, 1'b0, 2);
        add_vec(16'd1,   32'hDEAD_BEEF, 32'h0,         0, 1'b0, 1'b0, 1'b0, 1);
        add_vec(16'd64,  32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0, 1'b0, 1'b0, 64);
`ifdef LOADER_CHECKSUM_EN
        add_vec(16'd1,   32'h4433_2211, 32'h0,         0, 1'b0, 1'b0, 1'b0, 1);
        add_vec(16'd1,   32'h4433_2211, 32'h0,         0, 1'b0, 1'b1, 1'b1, 1);
`endif

        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_mem_addr", mem_addr,      BASE);
        chk("rst_mem_wd",   mem_wd,        32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_err",      32'(err),      32'd0);

        foreach (vecs[i]) begin
            fill_data(vecs[i].exp_n, vecs[i].w0, vecs[i].w1);
            run_load(vecs[i].len, vecs[i].gap, vecs[i].mid_start, vecs[i].csum_bad,
                     vecs[i].exp_err, vecs[i].exp_n, $sformatf("vec%0d", i));
        end

        // Reset two cycles after the third byte of the second word.
        fill_data(2, 32'h0000_0013, 32'h0010_0093);
        wr_addr_q.delete();
        wr_data_q.delete();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 7; i++) send_byte(data_q[i], 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_mem_we",   32'(mem_we),   32'd0);
        chk("mid_rst_mem_addr", mem_addr,      BASE);
        chk("mid_rst_mem_wd",   mem_wd,        32'd0);
        chk("mid_rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("mid_rst_done",     32'(done),     32'd0);
        chk("mid_rst_err",      32'(err),      32'd0);
        chk("mid_rst_nwrites",  32'(wr_addr_q.size()), 32'd1);
        reset = 1'b0;
        fill_data(1, 32'hCAFE_F00D, 32'h0);
        run_load(16'd1, 0, 1'b0, 1'b0, 1'b0, 1, "after_rst");

        // Randomized loads against the reference model.
        for (int it = 0; it < 20; it++) begin
            case ($urandom_range(0, 9))
                0:       len = 16'd0;
                1:       len = 16'($urandom_range(65, 2000));
                default: len = 16'($urandom_range(1, 6));
            endcase
            n = (len == 16'd0 || len > 16'(DEPTH)) ? 0 : int'(len);
            e = (len > 16'(DEPTH));
            data_q.delete();
            for (int i = 0; i < 4 * n; i++) data_q.push_back(8'($urandom));
            cb = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            cb = 1'($urandom_range(0, 1));
            if (cb && n > 0) e = 1'b1;
`endif
            run_load(len, 2, 1'b0, cb, e, n, $sformatf("rand%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the instruction-memory interface. Fetch only reads instruction memory by PC; this block fills it.
- Accepts a byte stream (valid/ready), packs bytes into 32-bit little-endian words, and issues single-cycle word writes at byte addresses BASE_ADDR, BASE_ADDR+4, …
- Drives cpu_hold so the core's PC flip-flop is kept in reset while a program is being loaded.

Parameters:
- DEPTH_WORDS, 64, instruction-memory capacity in 32-bit words; upper bound for the word count.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be a multiple of 4.

Ports:
- clock  input  1  single system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte; transfer occurs when in_valid && in_ready.
- mem_we  output  1  instruction-memory write enable, one cycle per word.
- mem_addr  output  32  byte write address.
- mem_wd  output  32  write data.
- cpu_hold  output  1  high while busy; ORed into the core reset.
- done  output  1  one-cycle pulse at end of a load.
- err  output  1  sticky error flag, cleared by the next accepted start or by reset.

Behaviour:
- Reset, with reset held high at a rising edge: state=IDLE, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wd=0, cpu_hold=0, done=0, err=0, and byte/word counters=0. Reset mid-load aborts immediately; no further write is issued, and memory already written is left as is.
- States and transitions:
  - IDLE → LEN0 on start. err is cleared and cpu_hold goes to 1 on the next cycle.
  - LEN0: the accepted byte is count[7:0]. Go to LEN1.
  - LEN1: the accepted byte is count[15:8].
    - count==0 → DONE.
    - count>DEPTH_WORDS → err=1, then DONE.
    - Otherwise → DATA.
  - DATA: accepted byte k (k=0..3) goes into word bits [8k+7:8k]. After byte 3 is accepted → WRITE.
  - WRITE: exactly one cycle.
    - mem_we=1, mem_addr=BASE_ADDR+4*idx, mem_wd=assembled word; idx increments.
    - If idx+1==count → DONE (or CSUM when the optional feature is compiled in); otherwise → DATA.
  - DONE: one cycle. done=1 and cpu_hold=0 in the same cycle. Next state is IDLE.
- in_ready is 1 only in LEN0, LEN1, DATA (and CSUM). It is 0 in IDLE, WRITE and DONE.
- in_valid without in_ready is ignored; bytes are never dropped or duplicated.
- Latency: the write occurs 1 cycle after the 4th byte of the word is accepted. Minimum load time is 3 + 5*count cycles from start to done.
- start outside IDLE is ignored. Stalls (in_valid=0) of any length are allowed in any accepting state.
- On a length error, no writes are issued and no data bytes are consumed.
- mem_addr/mem_wd hold their last value when mem_we=0.
- Word index width is clog2(DEPTH_WORDS)+1. Address arithmetic is 32-bit modulo.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, go to state CSUM and accept one byte.
  - Compare it with the XOR of all data bytes (the length bytes are excluded).
  - Mismatch → err=1. Then → DONE. Writes already issued are not undone.
- Undefined: no CSUM state. WRITE of the last word goes directly to DONE, and err arises only from the length check.

Decomposition:
- Shared package (the team's constants file for fetch/memory) holds:
  - the state encoding localparams IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE;
  - the word width (32) and the PC increment (4), the same constant Fetch uses for PC+4.
- One natural sub-module: loader_byte_packer. It takes byte, lane k and accept, and outputs the 32-bit word register plus a word_full flag. The controller stays in instr_mem_loader.

Test Plan:
- start; stream 02 00 | 13 00 00 00 | 93 00 10 00 with in_valid always high:
  - mem_we pulses twice: (addr 0x0, wd 0x00000013), then (addr 0x4, wd 0x00100093);
  - done 1 cycle after the 2nd write; cpu_hold high from the cycle after start through the cycle before done.
- Stream 00 00 → no mem_we; done 3 cycles after start; err=0.
- DEPTH_WORDS=64, stream 41 00 (count=65) → err=1, done, zero writes, in_ready=0 afterward until the next start.
- Same program as the first test, with in_valid toggled 1/0 every cycle and start reasserted mid-load → identical writes (same addresses and data), the extra start is ignored, and the total time is roughly doubled.
- Reset asserted 2 cycles after the 3rd data byte of word 1 → no write for word 1; all outputs at reset values next cycle; a fresh load then starts writing at addr 0x0.
- LOADER_CHECKSUM_EN, count=1, data 11 22 33 44, checksum 44 → err=0. Repeat with checksum 00 → err=1. The write of 0x44332211 occurs in both cases.
